// File: rtl/shifter32_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : shifter32_right_seq
// Purpose  : Iterative right shifter (SRL/SRA), one bit per clock, with a
//            Start/Busy/Done handshake toward the control unit.
// Revision : 1.0
// ============================================================================
module shifter32_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SA_BITS = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   X,
    input  logic [SA_BITS-1:0] Sa,
    input  logic               Arith,
    output logic [WIDTH-1:0]   Sh,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SA_BITS-1:0] C_ONE = SA_BITS'(1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [SA_BITS-1:0]   count_q, count_d;
    logic                 arith_q, arith_d;
    logic                 w_accept;
    logic                 w_fill;

    // A request is only seen when no shift is in flight; DONE may accept
    // directly so back-to-back operations lose no cycle.
    assign w_accept = Start && (state_q != ST_SHIFT);
    assign w_fill   = arith_q & sh_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        count_d = count_q;
        arith_d = arith_q;
        if (w_accept) begin
            sh_d    = X;
            count_d = Sa;
            arith_d = Arith;
            state_d = (Sa == '0) ? ST_DONE : ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    sh_d    = {w_fill, sh_q[WIDTH-1:1]};
                    count_d = count_q - C_ONE;
                    if (count_q == C_ONE) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            count_q <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            count_q <= count_d;
            arith_q <= arith_d;
        end
    end

    assign Sh   = sh_q;
    assign Busy = (state_q == ST_SHIFT);
    assign Done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shifter32_right_seq.sv
`default_nettype none
// Testbench for shifter32_right_seq: directed cases plus a randomized sweep
// checked against a plain >> / >>> reference.
module tb_shifter32_right_seq;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [31:0] X;
    logic [4:0]  Sa;
    logic        Arith;
    logic [31:0] Sh;
    logic        Busy;
    logic        Done;

    int n_vec;
    int n_err;

    shifter32_right_seq #(.WIDTH(32), .SA_BITS(5)) u_dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .X     (X),
        .Sa    (Sa),
        .Arith (Arith),
        .Sh    (Sh),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int sa, input bit ar);
        if (ar) return $unsigned($signed(x) >>> sa);
        return x >> sa;
    endfunction

    // Called just after a negedge with the DUT in IDLE or in its DONE cycle.
    // Returns at the negedge inside the Done cycle (or after the bound).
    task automatic do_op(input logic [31:0] x, input int sa, input bit ar,
                         input logic [31:0] exp, input int poke);
        int  lat;
        int  busy_n;
        bit  seen;
        Start = 1'b1;
        X     = x;
        Sa    = 5'(sa);
        Arith = ar;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        X     = $urandom;
        Sa    = 5'($urandom);
        Arith = 1'($urandom);
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                lat  = c;
                check("busy_in_done", {31'd0, Busy}, 32'd0);
                break;
            end
            if (Busy) busy_n++;
            if (c == poke) begin
                Start = 1'b1;
                X     = 32'hFFFF_FFFF;
                Sa    = 5'd1;
                Arith = 1'b1;
            end else begin
                Start = 1'b0;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, sa + 1);
        check("busy_cycles", busy_n, sa);
        check("result", Sh, exp);
    endtask

    // Idle cycles after a completed operation: result held, no handshake.
    task automatic idle_check(input int n, input logic [31:0] exp);
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            check("idle_done", {31'd0, Done}, 32'd0);
            check("idle_busy", {31'd0, Busy}, 32'd0);
            check("idle_hold", Sh, exp);
        end
    endtask

    initial begin
        logic [31:0] x;
        int          sa;
        bit          ar;
        logic [31:0] e;
        int          gap;
        n_vec = 0;
        n_err = 0;
        Rst   = 1'b1;
        Start = 1'b0;
        X     = 32'h0;
        Sa    = 5'd0;
        Arith = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_sh", Sh, 32'h0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        do_op(32'hF000_0000, 4, 1'b0, 32'h0F00_0000, 0);
        idle_check(2, 32'h0F00_0000);
        do_op(32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 0);
        idle_check(1, 32'hFFFF_FFFF);
        do_op(32'h7FFF_FFFF, 8, 1'b1, 32'h007F_FFFF, 0);
        idle_check(1, 32'h007F_FFFF);
        do_op(32'h1234_5678, 0, 1'b0, 32'h1234_5678, 0);
        idle_check(1, 32'h1234_5678);
        do_op(32'h0000_00F0, 4, 1'b0, 32'h0000_000F, 2);
        idle_check(2, 32'h0000_000F);

        // Abort a Sa=10 shift two cycles in.
        Start = 1'b1;
        X     = 32'hDEAD_BEEF;
        Sa    = 5'd10;
        Arith = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (2) @(negedge Clk);
        check("pre_abort_busy", {31'd0, Busy}, 32'd1);
        #2 Rst = 1'b1;
        #1;
        check("abort_sh", Sh, 32'h0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        idle_check(12, 32'h0);

        do_op(32'h0000_0100, 8, 1'b0, 32'h0000_0001, 0);
        do_op(32'h8000_0000, 1, 1'b1, 32'hC000_0000, 0);
        do_op(32'hA5A5_A5A5, 0, 1'b1, 32'hA5A5_A5A5, 0);
        do_op(32'h8000_0001, 0, 1'b0, 32'h8000_0001, 0);
        idle_check(1, 32'h8000_0001);

        for (int i = 0; i < 1000; i++) begin
            x   = $urandom;
            sa  = $urandom_range(0, 31);
            ar  = 1'($urandom);
            e   = ref_shift(x, sa, ar);
            do_op(x, sa, ar, e, (sa > 2) ? int'($urandom_range(0, sa)) : 0);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle_check(gap, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
